// File: rtl/fb_writer_pkg.sv
// Shared constants and types for the framebuffer writer: pixel field widths,
// default screen geometry, write-FSM state encoding and an RGB packing helper.
package fb_writer_pkg;

    localparam int WIDTH_BITS      = 10;
    localparam int HEIGHT_BITS     = 9;
    localparam int CHANNEL_BITS    = 8;
    localparam int FB_ADDR_BITS    = 19;
    localparam int FB_SCREEN_WIDTH = 640;
    localparam int FB_SCREEN_HEIGHT = 480;
    localparam int FB_FIFO_DEPTH   = 16;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_WRITE = 1'b1
    } wr_state_t;

    // Framebuffer word layout: red in the MSBs, blue in the LSBs.
    function automatic logic [3*CHANNEL_BITS-1:0] pack_rgb(
        input logic [CHANNEL_BITS-1:0] r,
        input logic [CHANNEL_BITS-1:0] g,
        input logic [CHANNEL_BITS-1:0] b
    );
        return {r, g, b};
    endfunction

endpackage

// File: rtl/pixel_fifo.sv
// Small synchronous FIFO for pending framebuffer writes. The head entry is
// read combinationally so the consumer can load it on the same edge it pops.
// A push while full is taken only when a pop happens on the same edge.
module pixel_fifo #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 43,
    localparam int CNT_BITS = $clog2(DEPTH + 1),
    localparam int PTR_BITS = $clog2(DEPTH)
) (
    input  logic                clk,
    input  logic                n_rst,
    input  logic                flush,
    input  logic                push,
    input  logic                pop,
    input  logic [WIDTH-1:0]    wdata,
    output logic [WIDTH-1:0]    rdata,
    output logic                full,
    output logic                empty,
    output logic [CNT_BITS-1:0] count
);

    logic [WIDTH-1:0]    mem [DEPTH];
    logic [PTR_BITS-1:0] wr_ptr_reg;
    logic [PTR_BITS-1:0] rd_ptr_reg;
    logic [CNT_BITS-1:0] count_reg;
    logic                do_push;
    logic                do_pop;

    assign full  = (count_reg == CNT_BITS'(DEPTH));
    assign empty = (count_reg == '0);
    assign count = count_reg;
    assign rdata = mem[rd_ptr_reg];

    // Flush wins over both operations; a full FIFO accepts only alongside a pop.
    assign do_pop  = pop && !empty && !flush;
    assign do_push = push && (!full || do_pop) && !flush;

    // Storage array, no reset needed on the data itself.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr_reg] <= wdata;
        end
    end

    // Pointers and occupancy; pointers wrap naturally since DEPTH is a power of two.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else if (flush) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_reg <= wr_ptr_reg + PTR_BITS'(1);
            end
            if (do_pop) begin
                rd_ptr_reg <= rd_ptr_reg + PTR_BITS'(1);
            end
            if (do_push && !do_pop) begin
                count_reg <= count_reg + CNT_BITS'(1);
            end else if (do_pop && !do_push) begin
                count_reg <= count_reg - CNT_BITS'(1);
            end
        end
    end

endmodule

// File: rtl/fb_writer.sv
// Framebuffer writer: takes the rasterizer pixel stream, discards off-screen
// pixels, converts the rest to linear addresses, queues them, and drains the
// queue to framebuffer SRAM with a hold-until-ack write handshake. The source
// cannot be stalled, so losses are reported on sticky flags.
module fb_writer
    import fb_writer_pkg::*;
#(
    parameter int DEPTH         = FB_FIFO_DEPTH,
    parameter int SCREEN_WIDTH  = FB_SCREEN_WIDTH,
    parameter int SCREEN_HEIGHT = FB_SCREEN_HEIGHT,
    parameter int ADDR_BITS     = FB_ADDR_BITS
) (
    input  logic                           clk,
    input  logic                           n_rst,
    input  logic                           data_avail_i,
    input  logic [WIDTH_BITS-1:0]          x_i,
    input  logic [HEIGHT_BITS-1:0]         y_i,
    input  logic [CHANNEL_BITS-1:0]        r_i,
    input  logic [CHANNEL_BITS-1:0]        g_i,
    input  logic [CHANNEL_BITS-1:0]        b_i,
    input  logic                           clear_i,
    output logic                           mem_we_o,
    output logic [ADDR_BITS-1:0]           mem_addr_o,
    output logic [3*CHANNEL_BITS-1:0]      mem_wdata_o,
    input  logic                           mem_ack_i,
    output logic [$clog2(DEPTH+1)-1:0]     fifo_count_o,
    output logic                           overflow_o,
    output logic                           oob_o,
    output logic                           idle_o
);

    localparam int DATA_BITS  = 3 * CHANNEL_BITS;
    localparam int ENTRY_BITS = ADDR_BITS + DATA_BITS;
    localparam int CNT_BITS   = $clog2(DEPTH + 1);

    logic                  in_bounds;
    logic [ADDR_BITS-1:0]  pix_addr;
    logic                  pix_valid;
    logic                  push;
    logic                  pop;
    logic                  fifo_full;
    logic                  fifo_empty;
    logic [ENTRY_BITS-1:0] fifo_wdata;
    logic [ENTRY_BITS-1:0] fifo_rdata;
    logic [CNT_BITS-1:0]   fifo_count;

    wr_state_t             state_reg;
    wr_state_t             state_next;
    logic [ADDR_BITS-1:0]  addr_reg;
    logic [DATA_BITS-1:0]  wdata_reg;
    logic                  overflow_reg;
    logic                  oob_reg;

    // A pixel arriving during a flush is ignored entirely.
    assign pix_valid  = data_avail_i && !clear_i;
    assign in_bounds  = (32'(x_i) < 32'(SCREEN_WIDTH)) && (32'(y_i) < 32'(SCREEN_HEIGHT));
    assign pix_addr   = ADDR_BITS'(y_i) * ADDR_BITS'(SCREEN_WIDTH) + ADDR_BITS'(x_i);
    assign fifo_wdata = {pix_addr, pack_rgb(r_i, g_i, b_i)};
    assign push       = pix_valid && in_bounds;

    pixel_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (ENTRY_BITS)
    ) u_fifo (
        .clk   (clk),
        .n_rst (n_rst),
        .flush (clear_i),
        .push  (push),
        .pop   (pop),
        .wdata (fifo_wdata),
        .rdata (fifo_rdata),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    // Write FSM state register.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next state: leave IDLE when work is queued; leave WRITE on an ack with nothing to reload.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE:  if (!fifo_empty && !clear_i) state_next = ST_WRITE;
            ST_WRITE: if (mem_ack_i && (fifo_empty || clear_i)) state_next = ST_IDLE;
            default:  state_next = ST_IDLE;
        endcase
    end

    // FSM outputs: write request and the pop that reloads the output registers.
    always_comb begin
        mem_we_o = 1'b0;
        pop      = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                pop = !fifo_empty && !clear_i;
            end
            ST_WRITE: begin
                mem_we_o = 1'b1;
                pop      = mem_ack_i && !fifo_empty && !clear_i;
            end
            default: begin
                mem_we_o = 1'b0;
                pop      = 1'b0;
            end
        endcase
    end

    // Output registers hold the current request until the next pop replaces it.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            addr_reg  <= '0;
            wdata_reg <= '0;
        end else if (pop) begin
            {addr_reg, wdata_reg} <= fifo_rdata;
        end
    end

    // Sticky loss flags; a flush clears them and suppresses same-cycle setting.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            overflow_reg <= 1'b0;
            oob_reg      <= 1'b0;
        end else if (clear_i) begin
            overflow_reg <= 1'b0;
            oob_reg      <= 1'b0;
        end else begin
            if (push && fifo_full && !pop) begin
                overflow_reg <= 1'b1;
            end
            if (pix_valid && !in_bounds) begin
                oob_reg <= 1'b1;
            end
        end
    end

    assign mem_addr_o   = addr_reg;
    assign mem_wdata_o  = wdata_reg;
    assign fifo_count_o = fifo_count;
    assign overflow_o   = overflow_reg;
    assign oob_o        = oob_reg;
    assign idle_o       = (state_reg == ST_IDLE) && fifo_empty;

endmodule

// File: doc/fb_writer.md
# fb_writer

Downstream stage of `gpu`. Consumes the pixel stream the rasterizer emits (`x_o`, `y_o`, `r_o`, `g_o`, `b_o` qualified by `data_avail`) and buffers it in a small FIFO. It converts each in-bounds pixel to a linear framebuffer address and writes it to framebuffer SRAM over a hold-until-ack write handshake. The `gpu` side has no backpressure, so the block absorbs memory stalls and flags any loss.

## Interface
Parameters:
- `DEPTH`, 16: FIFO entries (power of two).
- `SCREEN_WIDTH`, 640: pixels per row.
- `SCREEN_HEIGHT`, 480: rows.
- `ADDR_BITS`, 19: framebuffer address width. SCREEN_WIDTH*SCREEN_HEIGHT must be ≤ 2^ADDR_BITS.

Ports:
- `clk`  in  1  system clock.
- `n_rst`  in  1  asynchronous active-low reset.
- `data_avail_i`  in  1  pixel valid, from `gpu.data_avail`.
- `x_i`  in  `WIDTH_BITS`  pixel column.
- `y_i`  in  `HEIGHT_BITS`  pixel row.
- `r_i`, `g_i`, `b_i`  in  `CHANNEL_BITS` each  colour channels.
- `clear_i`  in  1  synchronous flush; also clears the flags.
- `mem_we_o`  out  1  write request.
- `mem_addr_o`  out  `ADDR_BITS`  linear address.
- `mem_wdata_o`  out  3*`CHANNEL_BITS`  packed {r,g,b}, r in MSBs.
- `mem_ack_i`  in  1  write accepted.
- `fifo_count_o`  out  $clog2(DEPTH+1)  current FIFO occupancy.
- `overflow_o`  out  1  sticky: a pixel was dropped because the FIFO was full.
- `oob_o`  out  1  sticky: a pixel was discarded as out of bounds.
- `idle_o`  out  1  FIFO empty and no write outstanding.

## Operation
- Push path:
  - Pixel sampled on each edge where `data_avail_i`=1.
  - If x ≥ SCREEN_WIDTH or y ≥ SCREEN_HEIGHT: discard and set `oob_o`.
  - Otherwise push {addr = y*SCREEN_WIDTH + x (unsigned, ADDR_BITS wide), data = {r,g,b}}.
- Full: a push is accepted only if occupancy < DEPTH, or a pop occurs on the same edge. Otherwise the pixel is dropped and `overflow_o` is set.
- Write FSM:
  - IDLE: if FIFO non-empty, pop head into output registers, set `mem_we_o`=1, go to WRITE.
  - WRITE: `mem_we_o`, `mem_addr_o` and `mem_wdata_o` hold stable until `mem_ack_i`=1 is sampled. On ack, if FIFO non-empty and `clear_i`=0, pop the next head and stay in WRITE (back-to-back writes); else `mem_we_o`←0 and go to IDLE.
- `clear_i`=1:
  - FIFO emptied; `overflow_o` and `oob_o` cleared.
  - A pixel arriving the same cycle is dropped without setting any flag.
  - An in-flight write (already in output registers) still completes on ack; no reload follows.
- `idle_o` = (state==IDLE) && (FIFO empty).
- Writes reach memory in the same order pixels were accepted.

## Timing
- Reset (async, `n_rst`=0): FSM=IDLE, FIFO empty; all outputs 0 except `idle_o`=1.
- Reset mid-write drops `mem_we_o` immediately. The memory side tolerates an abandoned request.
- Latency: pixel sampled at edge N → `mem_we_o`=1 with its addr/data after edge N+1.
- Throughput: one write per cycle while `mem_ack_i` is held at 1.
- Capacity under a full stall: DEPTH in the FIFO plus 1 in the output registers.
- `fifo_count_o` and the flags update on the same edge as the causing push/pop/clear.

## Structure
- `gpu_definitions.vh`:
  - Already holds `WIDTH_BITS`, `HEIGHT_BITS`, `CHANNEL_BITS`.
  - Add `FB_ADDR_BITS`, `SCREEN_WIDTH` and `SCREEN_HEIGHT`, so the `gpu` top and `fb_writer` share them.
- Sub-module `pixel_fifo`:
  - Synchronous FIFO, parameters DEPTH and entry width (ADDR_BITS + 3*CHANNEL_BITS).
  - Ports: push, pop, full, empty, count.
  - Simultaneous push/pop when full is legal.
- `fb_writer` contains the bounds check, address multiply, FSM, output registers and flags.

## Test plan
- Reset → `mem_we_o`=0, `mem_addr_o`=0, `mem_wdata_o`=0, `fifo_count_o`=0, flags 0, `idle_o`=1.
- Single pixel x=3, y=2, rgb=0x12/0x34/0x56, `mem_ack_i` held 1 → one cycle of `mem_we_o`=1 at edge N+1, addr=1283, data=0x123456; then `idle_o`=1.
- `mem_ack_i`=0, 20 pixels on consecutive cycles → 17 accepted, 3 dropped, `overflow_o`=1, `fifo_count_o`=16. Raising ack → 17 back-to-back writes in input order.
- Pixel x=640, y=0 → no write, `oob_o`=1, `idle_o` stays 1.
- Ack stalled 5 cycles → `mem_we_o`/addr/data stable all 5 cycles; the write completes on the cycle ack is sampled.
- Stalled write with 4 queued, pulse `clear_i` → `fifo_count_o`=0, flags cleared. On ack, only the in-flight write completes, then `idle_o`=1.
